spi_slave_gen: RTL and testbench
================================

// Module: spi_slave_gen
// PURPOSE
//  Parametrised SPI slave, successor of the 8-bit mode-0 receiver. Adds word width,
//  all four CPOL/CPHA modes, multi-word frames, framing-error detect and optional
//  MISO transmit. Sits between the pad ring and the register/colour-command decoder,
//  fully in the clk domain; sck/mosi/cs are oversampled, never used as clocks.
// PARAMETERS
//  DATA_W       8  bits per word (4..32)
//  CPOL         0  sck idle level
//  CPHA         0  0: sample on leading edge; 1: sample on trailing edge
//  SYNC_STAGES  2  synchroniser depth on sck/mosi/cs (2..3)
//  MSB_FIRST    1  1: MSB shifted first (in and out); 0: LSB first
// PORTS
//  clk       in   1       system clock
//  reset     in   1       asynchronous, active-low reset
//  sck       in   1       SPI clock from master (async)
//  cs        in   1       chip select, active-low (async)
//  mosi      in   1       master-out data (async)
//  miso      out  1       slave-out data
//  miso_oe   out  1       1 while frame active (pad tristate enable)
//  data      out  DATA_W  last received word, held until next word completes
//  rdy       out  1       1-clk pulse: data updated
//  word_idx  out  8       index of the word in data within the current frame (0-based)
//  frm_err   out  1       1-clk pulse: cs deasserted with partial word
//  tx_data   in   DATA_W  word to transmit next
//  tx_ack    out  1       1-clk pulse: tx_data captured into shifter
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0, shifters/counters 0, FSM IDLE.
//  - Inputs pass SYNC_STAGES flops; edges detected on synced sck vs 1-cycle delayed
//    copy. Leading edge = idle->active (CPOL). Sample edge = leading if CPHA=0 else
//    trailing; shift edge = the other one. Requires f_clk >= 6*f_sck.
//  - FSM IDLE: cs_s=1; bit_cnt=0; word_idx cleared on next rdy. cs_s 1->0 -> ACTIVE.
//  - ACTIVE: on sample edge shift mosi_s into rx shifter, bit_cnt++. When bit_cnt
//    reaches DATA_W: data <= completed word (incl. current bit) and rdy=1 on the
//    following clk, bit_cnt <= 0, stay ACTIVE (next word). word_idx = 0 for first
//    word of frame, +1 per word, saturates at 255.
//  - rdy latency: 1 clk after the synced sample edge (SYNC_STAGES+2 clk after pin).
//  - cs_s 0->1 in ACTIVE: if bit_cnt!=0 pulse frm_err, partial word discarded (data,
//    rdy untouched); -> IDLE. cs rise coincident with final sample edge: word
//    completes (rdy=1), no frm_err.
//  - Edges seen while cs_s=1 are ignored. reset mid-frame aborts silently, no pulses.
//  - data never glitches: updated only with rdy.
// CONFIGURATION
//  SPI_MISO_EN defined: tx shifter loads tx_data at frame start (cs_s fall) and at each
//  word boundary; tx_ack pulses same clk. CPHA=0: first bit on miso at load; CPHA=1:
//  first bit on first shift edge. Subsequent bits change on shift edges. miso_oe=~cs_s.
//  Not defined: no tx shifter; miso=0, miso_oe=0, tx_ack=0, tx_data unused.
// STRUCTURE
//  - Package spi_pkg: mode localparams (SPI_MODE0..3 as {CPOL,CPHA}), FSM state
//    encodings (ST_IDLE, ST_ACTIVE), MAX_WORD_IDX=255.
//  - Sub-module spi_sync: SYNC_STAGES-deep synchroniser, 3 bits wide, async reset to
//    {sck=CPOL, cs=1, mosi=0}.
//  - Top holds edge detect, FSM, rx/tx shifters, counters.
// TESTING
//  1 Mode0, DATA_W=8: frame 0xA5 -> data=0xA5, rdy 1 pulse, word_idx=0, frm_err=0.
//  2 Modes 1/2/3 each: send 0x3C -> data=0x3C; mis-sampling edge fails check.
//  3 3-word frame 0x11,0x22,0x33 under one cs -> 3 rdy pulses, word_idx 0,1,2.
//  4 cs rises after 5 bits -> frm_err pulse, data keeps prior value, no rdy.
//  5 SPI_MISO_EN, tx_data=0xC3, mode0 and mode1 -> master reads 0xC3; tx_ack at cs
//    fall and at word boundary; without macro miso stays 0.
//  6 reset=0 mid-word then new frame 0x5A -> no stale bits, data=0x5A, word_idx=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the oversampled SPI slave: mode encodings, FSM states
// and the word-index saturation helper.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int MAX_WORD_IDX = 255;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } st_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'(MAX_WORD_IDX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for the three SPI pins, bit order {sck, cs, mosi}.
// Resets to an idle bus so no false edge is seen when reset releases.
module spi_sync #(
  parameter int STAGES = 2,
  parameter bit CPOL   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] d_in,
  output logic [2:0] d_out
);

  localparam logic [2:0] RST_VAL = {CPOL, 1'b1, 1'b0};

  logic [2:0] stg_q [STAGES];
  logic [2:0] stg_d [STAGES];

  always_comb begin
    stg_d[0] = d_in;
    for (int i = 1; i < STAGES; i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) stg_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < STAGES; i++) stg_q[i] <= stg_d[i];
    end
  end

  assign d_out = stg_q[STAGES-1];

endmodule

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave (all CPOL/CPHA modes, multi-word frames, framing error).
// Define SPI_MISO_EN to build the MISO transmit shifter; otherwise miso/miso_oe/tx_ack are 0.
module spi_slave_gen
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] data,
  output logic              rdy,
  output logic [7:0]        word_idx,
  output logic              frm_err,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ack,
  output st_e               dbg_state
);

  localparam int         CNT_W       = $clog2(DATA_W + 1);
  localparam logic       IDLE_LVL    = 1'(CPOL);
  localparam logic [1:0] MODE        = {1'(CPOL), 1'(CPHA)};
  localparam bit         SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);
  localparam bit         MSB_F       = (MSB_FIRST != 0);

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    return MSB_F ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
  endfunction

  logic [2:0] sync_out;
  logic       sck_s, cs_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .CPOL(IDLE_LVL)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  ({sck, cs, mosi}),
    .d_out (sync_out)
  );
  assign {sck_s, cs_s, mosi_s} = sync_out;

  // One aligned stage after the synchroniser: edges are detected between d1 and d2,
  // and mosi_d1 is the bit that belongs to that edge.
  logic sck_d1_q, sck_d2_q, cs_d1_q, cs_d2_q, mosi_d1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_d1_q  <= IDLE_LVL;
      sck_d2_q  <= IDLE_LVL;
      cs_d1_q   <= 1'b1;
      cs_d2_q   <= 1'b1;
      mosi_d1_q <= 1'b0;
    end else begin
      sck_d1_q  <= sck_s;
      sck_d2_q  <= sck_d1_q;
      cs_d1_q   <= cs_s;
      cs_d2_q   <= cs_d1_q;
      mosi_d1_q <= mosi_s;
    end
  end

  logic lead_edge, trail_edge, sample_edge, cs_fall, cs_rise;

  assign lead_edge   = (sck_d1_q ^ sck_d2_q) & (sck_d1_q != IDLE_LVL);
  assign trail_edge  = (sck_d1_q ^ sck_d2_q) & (sck_d1_q == IDLE_LVL);
  assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
  assign cs_fall     = cs_d2_q & ~cs_d1_q;
  assign cs_rise     = ~cs_d2_q & cs_d1_q;

  st_e               state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, cnt_nxt;
  logic [DATA_W-1:0] rx_q, rx_d, rx_nxt;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        widx_q, widx_d, wcnt_q, wcnt_d;
  logic              rdy_q, rdy_d, frm_err_q, frm_err_d;
  logic              word_done;

  // rdy and frm_err are single-clk strobes with no back-pressure: data/word_idx
  // are valid from the rdy clk until the next rdy, and the consumer must take them then.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    data_d    = data_q;
    widx_d    = widx_q;
    wcnt_d    = wcnt_q;
    rdy_d     = 1'b0;
    frm_err_d = 1'b0;
    word_done = 1'b0;
    rx_nxt    = shift_in(rx_q, mosi_d1_q);
    cnt_nxt   = bit_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          rx_d    = '0;
          wcnt_d  = '0;
        end
      end
      ST_ACTIVE: begin
        if (sample_edge) begin
          if (cnt_nxt == CNT_W'(DATA_W)) begin
            data_d    = rx_nxt;
            rdy_d     = 1'b1;
            widx_d    = wcnt_q;
            wcnt_d    = sat_inc8(wcnt_q);
            bit_cnt_d = '0;
            rx_d      = '0;
            word_done = 1'b1;
          end else begin
            bit_cnt_d = cnt_nxt;
            rx_d      = rx_nxt;
          end
        end
        // A word finishing in the same clk as cs rising leaves bit_cnt_d at 0: no error.
        if (cs_rise) begin
          if (bit_cnt_d != '0) frm_err_d = 1'b1;
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          rx_d      = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      data_q    <= '0;
      widx_q    <= '0;
      wcnt_q    <= '0;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      data_q    <= data_d;
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
      rdy_q     <= rdy_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign word_idx  = widx_q;
  assign frm_err   = frm_err_q;
  assign dbg_state = state_q;

`ifdef SPI_MISO_EN
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d, tx_ack_q, tx_ack_d;
  logic              shift_edge, tx_load, shift_ok;

  assign shift_edge = SAMPLE_LEAD ? trail_edge : lead_edge;
  assign tx_load    = ((state_q == ST_IDLE) && cs_fall) || (word_done && !cs_rise);
  // With CPHA=0 the first bit is presented at load, so the trailing edge that closes
  // a word (bit_cnt already 0) must not shift it away.
  assign shift_ok   = (state_q == ST_ACTIVE) && shift_edge && (!SAMPLE_LEAD || (bit_cnt_q != '0));

  always_comb begin
    tx_d     = tx_q;
    miso_d   = miso_q;
    tx_ack_d = 1'b0;
    if (tx_load) begin
      tx_ack_d = 1'b1;
      if (SAMPLE_LEAD) begin
        miso_d = MSB_F ? tx_data[DATA_W-1] : tx_data[0];
        tx_d   = MSB_F ? {tx_data[DATA_W-2:0], 1'b0} : {1'b0, tx_data[DATA_W-1:1]};
      end else begin
        tx_d = tx_data;
      end
    end else if (shift_ok) begin
      miso_d = MSB_F ? tx_q[DATA_W-1] : tx_q[0];
      tx_d   = MSB_F ? {tx_q[DATA_W-2:0], 1'b0} : {1'b0, tx_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q     <= '0;
      miso_q   <= 1'b0;
      tx_ack_q <= 1'b0;
    end else begin
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      tx_ack_q <= tx_ack_d;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = ~cs_d1_q;
  assign tx_ack  = tx_ack_q;
`else
  logic unused_ok;
  assign unused_ok = ^{tx_data, word_done};
  assign miso      = 1'b0;
  assign miso_oe   = 1'b0;
  assign tx_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: four instances (modes 0..3, DATA_W=8) driven by a
// bit-level SPI master task; table of frames plus hand sequences for corner cases.
module tb_spi_slave_gen;
  import spi_pkg::*;

  localparam int CLK_P = 10;
  localparam int HALF  = 6;

`ifdef SPI_MISO_EN
  localparam bit MISO_ON = 1'b1;
`else
  localparam bit MISO_ON = 1'b0;
`endif

  logic       clk, reset, mosi_i;
  logic       sck_i [4];
  logic       cs_i [4];
  logic [7:0] tx_data_i;
  logic       miso_o [4], miso_oe_o [4], rdy_o [4], frm_err_o [4], tx_ack_o [4];
  logic [7:0] data_o [4], widx_o [4];
  st_e        dbg_o [4];

  int   checks, errors;
  int   rdy_cnt [4], ferr_cnt [4], ack_cnt [4], oe_cnt [4], miso_hi_cnt [4];
  int   glitch_cnt;
  time  samp_t [4], rdy_t [4];
  logic [7:0]  prev_data [4];
  logic [17:0] exp_q [$];
  logic [17:0] got_q [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_gen #(
      .DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2), .MSB_FIRST(1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .sck       (sck_i[g]),
      .cs        (cs_i[g]),
      .mosi      (mosi_i),
      .miso      (miso_o[g]),
      .miso_oe   (miso_oe_o[g]),
      .data      (data_o[g]),
      .rdy       (rdy_o[g]),
      .word_idx  (widx_o[g]),
      .frm_err   (frm_err_o[g]),
      .tx_data   (tx_data_i),
      .tx_ack    (tx_ack_o[g]),
      .dbg_state (dbg_o[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #(CLK_P / 2) clk = ~clk;

  initial begin
    #(500000);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // monitor: pulse counters and rdy capture, sampled on the falling edge
  initial begin
    glitch_cnt = 0;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        if (rdy_o[m]) begin
          rdy_cnt[m]++;
          rdy_t[m] = $time;
          got_q.push_back({2'(m), widx_o[m], data_o[m]});
        end
        if (frm_err_o[m]) ferr_cnt[m]++;
        if (tx_ack_o[m])  ack_cnt[m]++;
        if (miso_oe_o[m]) oe_cnt[m]++;
        if (miso_o[m])    miso_hi_cnt[m]++;
        if (reset === 1'b1 && data_o[m] !== prev_data[m] && !rdy_o[m]) glitch_cnt++;
        prev_data[m] = data_o[m];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int m = 0; m < 4; m++) begin
      rdy_cnt[m] = 0; ferr_cnt[m] = 0; ack_cnt[m] = 0; oe_cnt[m] = 0; miso_hi_cnt[m] = 0;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // driver: MSB-first master; wv holds up to three words, word 0 in [23:16]
  task automatic spi_frame(input int m, input logic [23:0] wv, input int nbits,
                           input bit cs_on_last, output logic [23:0] rd);
    bit cpol, cpha;
    cpol = 1'(m >> 1);
    cpha = 1'(m);
    rd = '0;
    cs_i[m] = 1'b0;
    if (!cpha) mosi_i = wv[23];
    for (int b = 0; b < nbits; b++) begin
      repeat (HALF) @(negedge clk);
      if (!cpha) begin
        sck_i[m]  = ~cpol;
        samp_t[m] = $time;
        rd[23-b]  = miso_o[m];
        repeat (HALF) @(negedge clk);
        sck_i[m] = cpol;
        if (b + 1 < nbits) mosi_i = wv[22-b];
      end else begin
        sck_i[m] = ~cpol;
        repeat (2) @(negedge clk);
        mosi_i = wv[23-b];
        repeat (HALF - 2) @(negedge clk);
        sck_i[m]  = cpol;
        samp_t[m] = $time;
        rd[23-b]  = miso_o[m];
        if (cs_on_last && b == nbits - 1) cs_i[m] = 1'b1;
      end
    end
    repeat (HALF) @(negedge clk);
    cs_i[m] = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic chk_scoreboard(input string name);
    chk({name, "_sb_size"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({name, "_sb_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  typedef struct {
    int         mode;
    int         nw;
    logic [23:0] words;
    int         exp_rdy;
    logic [7:0] exp_data;
    logic [7:0] exp_idx;
  } vec_t;

  vec_t        vecs [8];
  logic [23:0] rd;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    mosi_i = 1'b0;
    tx_data_i = 8'hC3;
    for (int m = 0; m < 4; m++) begin
      sck_i[m] = 1'(m >> 1);
      cs_i[m]  = 1'b1;
    end
    clear_counts();
    repeat (3) @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_data%0d", m),    32'(data_o[m]),    0);
      chk($sformatf("rst_rdy%0d", m),     32'(rdy_o[m]),     0);
      chk($sformatf("rst_idx%0d", m),     32'(widx_o[m]),    0);
      chk($sformatf("rst_ferr%0d", m),    32'(frm_err_o[m]), 0);
      chk($sformatf("rst_miso%0d", m),    32'(miso_o[m]),    0);
      chk($sformatf("rst_oe%0d", m),      32'(miso_oe_o[m]), 0);
      chk($sformatf("rst_ack%0d", m),     32'(tx_ack_o[m]),  0);
      chk($sformatf("rst_state%0d", m),   32'(dbg_o[m]),     32'(ST_IDLE));
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);

    vecs[0] = '{0, 1, 24'hA50000, 1, 8'hA5, 8'd0};
    vecs[1] = '{1, 1, 24'h3C0000, 1, 8'h3C, 8'd0};
    vecs[2] = '{2, 1, 24'h3C0000, 1, 8'h3C, 8'd0};
    vecs[3] = '{3, 1, 24'h3C0000, 1, 8'h3C, 8'd0};
    vecs[4] = '{0, 3, 24'h112233, 3, 8'h33, 8'd2};
    vecs[5] = '{2, 3, 24'h817EFF, 3, 8'hFF, 8'd2};
    vecs[6] = '{3, 2, 24'h00C300, 2, 8'hC3, 8'd1};
    vecs[7] = '{1, 2, 24'h5A9600, 2, 8'h96, 8'd1};

    for (int i = 0; i < 8; i++) begin
      int m;
      m = vecs[i].mode;
      clear_counts();
      for (int w = 0; w < vecs[i].nw; w++)
        exp_q.push_back({2'(m), 8'(w), vecs[i].words[23-8*w -: 8]});
      spi_frame(m, vecs[i].words, 8 * vecs[i].nw, 1'b0, rd);
      chk($sformatf("v%0d_rdy_cnt", i), 32'(rdy_cnt[m]), 32'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_data", i),    32'(data_o[m]),  32'(vecs[i].exp_data));
      chk($sformatf("v%0d_word_idx", i), 32'(widx_o[m]), 32'(vecs[i].exp_idx));
      chk($sformatf("v%0d_frm_err", i), 32'(ferr_cnt[m]), 0);
      chk($sformatf("v%0d_rdy_latency", i), 32'(rdy_t[m] - samp_t[m]), 32'(4 * CLK_P));
      chk_scoreboard($sformatf("v%0d", i));
      for (int w = 0; w < vecs[i].nw; w++)
        chk($sformatf("v%0d_miso_w%0d", i, w), 32'(rd[23-8*w -: 8]), MISO_ON ? 32'hC3 : 32'h0);
      chk($sformatf("v%0d_tx_ack_cnt", i), 32'(ack_cnt[m]), MISO_ON ? 32'(vecs[i].nw + 1) : 32'h0);
      chk($sformatf("v%0d_miso_oe_seen", i), 32'(oe_cnt[m] != 0), 32'(MISO_ON));
      chk($sformatf("v%0d_miso_hi_seen", i), 32'(miso_hi_cnt[m] != 0), 32'(MISO_ON));
      chk($sformatf("v%0d_state_idle", i), 32'(dbg_o[m]), 32'(ST_IDLE));
    end

    // cs rises after 5 bits: framing error, previous word kept
    clear_counts();
    spi_frame(0, 24'hF00000, 5, 1'b0, rd);
    chk("partial_frm_err", 32'(ferr_cnt[0]), 1);
    chk("partial_rdy_cnt", 32'(rdy_cnt[0]), 0);
    chk("partial_data",    32'(data_o[0]),  32'h33);
    chk("partial_idx",     32'(widx_o[0]),  2);

    // cs rise in the same clk as the final sample edge: word completes cleanly
    clear_counts();
    exp_q.push_back({2'd1, 8'd0, 8'h69});
    spi_frame(1, 24'h690000, 8, 1'b1, rd);
    chk("coinc_rdy_cnt", 32'(rdy_cnt[1]), 1);
    chk("coinc_data",    32'(data_o[1]),  32'h69);
    chk("coinc_frm_err", 32'(ferr_cnt[1]), 0);
    chk_scoreboard("coinc");

    // reset in the middle of a word, then a clean frame
    clear_counts();
    cs_i[0] = 1'b0;
    mosi_i  = 1'b1;
    repeat (3) begin
      repeat (HALF) @(negedge clk);
      sck_i[0] = 1'b1;
      repeat (HALF) @(negedge clk);
      sck_i[0] = 1'b0;
    end
    repeat (2) @(negedge clk);
    cs_i[0] = 1'b1;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("midrst_data%0d", m),  32'(data_o[m]), 0);
      chk($sformatf("midrst_idx%0d", m),   32'(widx_o[m]), 0);
      chk($sformatf("midrst_state%0d", m), 32'(dbg_o[m]),  32'(ST_IDLE));
    end
    reset = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    chk("midrst_frm_err", 32'(ferr_cnt[0]), 0);
    chk("midrst_rdy_cnt", 32'(rdy_cnt[0]),  0);
    exp_q.push_back({2'd0, 8'd0, 8'h5A});
    spi_frame(0, 24'h5A0000, 8, 1'b0, rd);
    chk("after_rst_rdy_cnt", 32'(rdy_cnt[0]), 1);
    chk("after_rst_data",    32'(data_o[0]),  32'h5A);
    chk("after_rst_idx",     32'(widx_o[0]),  0);
    chk_scoreboard("after_rst");

    chk("data_only_with_rdy", 32'(glitch_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
